// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and helpers for the data-memory arbiter
package dmem_arbiter_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_EXT = 1'b1
    } arb_state_e;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// rtl/dmem_arbiter_sat_counter.sv - saturating up-counter with clear priority
module sat_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority arbiter sharing dmem with an external master
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = cnt_width(STARVE_LIMIT);
    localparam int BW = cnt_width(BURST_MAX - 1);
    localparam logic [SW-1:0] STARVE_PRE = SW'(STARVE_LIMIT - 1);

    arb_state_e        state_q, state_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

    logic          starve_inc, starve_clr, starve_full, starve_hit;
    logic          beat_inc, beat_clr, beat_last;
    logic [SW-1:0] starve_q;
    logic [BW-1:0] beat_q;

    logic ext_sel;

    sat_counter #(.W(SW), .MAX(STARVE_LIMIT)) u_starve_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .count  (starve_q),
        .at_max (starve_full)
    );

    // Saturates at the last allowed beat so an unbounded burst still ends
    // promptly once the CPU starts waiting.
    sat_counter #(.W(BW), .MAX(BURST_MAX - 1)) u_beat_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (beat_inc),
        .clr    (beat_clr),
        .count  (beat_q),
        .at_max (beat_last)
    );

    // The denied cycle that brings the count up to the limit is the last
    // one ext has to wait; the hand-over happens at the end of that cycle.
    assign starve_hit = starve_full || (starve_q == STARVE_PRE);

    assign ext_sel   = (state_q == S_EXT);
    assign ext_gnt   = ext_sel && ext_req;
    assign cpu_stall = ext_sel && cpu_valid;
    assign mem_addr  = ext_sel ? ext_addr  : cpu_addr;
    assign mem_wdata = ext_sel ? ext_wdata : cpu_wdata;
    assign mem_we    = reset && (ext_sel ? (ext_req && ext_we) : (cpu_valid && cpu_we));
    assign cpu_rdata = mem_rdata;

    always_comb begin
        state_d    = state_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        beat_inc   = 1'b0;
        beat_clr   = 1'b0;
        case (state_q)
            S_CPU: begin
                if (ext_req && cpu_valid) begin
                    starve_inc = 1'b1;
                end else begin
                    starve_clr = 1'b1;
                end
                if (ext_req && (!cpu_valid || starve_hit)) begin
                    state_d    = S_EXT;
                    beat_clr   = 1'b1;
                    starve_clr = 1'b1;
                end
            end
            S_EXT: begin
                starve_clr = 1'b1;
                beat_inc   = ext_req;
                if (!ext_req || (cpu_valid && beat_last)) begin
                    state_d = S_CPU;
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    always_comb begin
        ext_rvalid_d = ext_gnt && !ext_we;
        ext_rdata_d  = ext_rdata_q;
        if (ext_gnt && !ext_we) begin
            ext_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_CPU;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int BURST_MAX    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        mem_clr;
    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port dmem: combinational read, write at the rising edge.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Field order: cpu_valid cpu_we ext_req ext_we | gnt stall mem_we ext_on_bus
    typedef struct packed {
        logic cv, cw, er, ew;
        logic g, s, w, x;
    } vec_t;

    vec_t tbl[$];

    logic [31:0] ref_mem [256];
    logic        m_ext, m_rvalid;
    logic [31:0] m_rdata;
    int          m_waited, m_beats;
    logic        exp_gnt, exp_stall, exp_we, last_gnt;
    logic [31:0] exp_addr, exp_wd;

    initial begin
        reset = 1'b0; mem_clr = 1'b1;
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hC0DE0001;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h200; ext_wdata = 32'hE0E0E0E0;

        // Reset held with a CPU write pending: nothing may reach memory.
        step(); step();
        @(negedge clk);
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst ext_gnt", 64'(ext_gnt), 64'd0);
        check("rst ext_rvalid", 64'(ext_rvalid), 64'd0);
        check("rst ext_rdata", 64'(ext_rdata), 64'd0);
        check("rst cpu_stall", 64'(cpu_stall), 64'd0);

        // Starvation, priority at count 2, early release, unbounded idle burst.
        for (int i = 0; i < 4; i++) tbl.push_back(8'b1011_0000);
        for (int i = 0; i < 4; i++) tbl.push_back(8'b1011_1111);
        for (int i = 0; i < 4; i++) tbl.push_back(8'b1111_0010);
        for (int i = 0; i < 2; i++) tbl.push_back(8'b1111_1111);
        tbl.push_back(8'b1101_0101);
        tbl.push_back(8'b1001_0000);
        tbl.push_back(8'b0010_0000);
        for (int i = 0; i < 5; i++) tbl.push_back(8'b0010_1001);
        tbl.push_back(8'b1010_1101);
        tbl.push_back(8'b1010_0000);
        tbl.push_back(8'b0000_0000);

        @(posedge clk); #1;
        reset = 1'b1; mem_clr = 1'b0;
        foreach (tbl[i]) begin
            if (i != 0) step();
            {cpu_valid, cpu_we, ext_req, ext_we} = {tbl[i].cv, tbl[i].cw, tbl[i].er, tbl[i].ew};
            @(negedge clk);
            check($sformatf("vec%0d gnt", i), 64'(ext_gnt), 64'(tbl[i].g));
            check($sformatf("vec%0d stall", i), 64'(cpu_stall), 64'(tbl[i].s));
            check($sformatf("vec%0d mem_we", i), 64'(mem_we), 64'(tbl[i].w));
            check($sformatf("vec%0d mem_addr", i), 64'(mem_addr), tbl[i].x ? 64'h200 : 64'h100);
        end

        // Idle CPU: ext write then back-to-back read of the same word.
        step();
        cpu_valid = 1'b0; ext_req = 1'b1; ext_we = 1'b1;
        ext_addr = 32'h40; ext_wdata = 32'hDEADBEEF;
        @(negedge clk); check("t2 gnt latency", 64'(ext_gnt), 64'd0);
        step();
        @(negedge clk); check("t2 wr gnt", 64'(ext_gnt), 64'd1);
        check("t2 wr mem_we", 64'(mem_we), 64'd1);
        step(); ext_we = 1'b0;
        @(negedge clk); check("t2 rd gnt", 64'(ext_gnt), 64'd1);
        check("t2 rvalid after write", 64'(ext_rvalid), 64'd0);
        check("t2 cpu_rdata passthru", 64'(cpu_rdata), 64'hDEADBEEF);
        step(); ext_req = 1'b0;
        @(negedge clk); check("t2 rvalid", 64'(ext_rvalid), 64'd1);
        check("t2 rdata", 64'(ext_rdata), 64'hDEADBEEF);
        check("t2 release mem_we", 64'(mem_we), 64'd0);
        step();
        @(negedge clk); check("t2 rvalid drop", 64'(ext_rvalid), 64'd0);

        // Reset asserted during beat 2 of an ext write burst.
        step();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h80; ext_wdata = 32'h11111111;
        @(negedge clk); check("t6 gnt latency", 64'(ext_gnt), 64'd0);
        step();
        @(negedge clk); check("t6 beat0 gnt", 64'(ext_gnt), 64'd1);
        step(); ext_addr = 32'h84; ext_wdata = 32'h22222222;
        @(negedge clk); check("t6 beat1 gnt", 64'(ext_gnt), 64'd1);
        step(); ext_addr = 32'h88; ext_wdata = 32'h33333333;
        #2 reset = 1'b0;
        #1 check("t6 rst mem_we", 64'(mem_we), 64'd0);
        check("t6 rst gnt", 64'(ext_gnt), 64'd0);
        step(); reset = 1'b1;
        @(negedge clk);
        check("t6 state cpu after rst", 64'(ext_gnt), 64'd0);
        check("t6 mem beat0", 64'(mem[32]), 64'h11111111);
        check("t6 mem beat1", 64'(mem[33]), 64'h22222222);
        check("t6 mem beat2 absent", 64'(mem[34]), 64'd0);
        step(); ext_req = 1'b0;

        // Randomized traffic against a cycle-level behavioural model.
        step();
        cpu_valid = 1'b0; mem_clr = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        m_ext = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_waited = 0; m_beats = 0;
        last_gnt = 1'b0;
        step(); mem_clr = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (n != 0) step();
            if (!ext_req || last_gnt || ($urandom_range(7) == 0)) begin
                ext_req   = ($urandom_range(9) < 6);
                ext_we    = 1'($urandom_range(1));
                ext_addr  = 32'($urandom_range(63)) << 2;
                ext_wdata = $urandom;
            end
            cpu_valid = ($urandom_range(9) < 7);
            cpu_we    = 1'($urandom_range(1));
            cpu_addr  = 32'($urandom_range(63)) << 2;
            cpu_wdata = $urandom;
            @(negedge clk);
            exp_gnt   = m_ext && ext_req;
            exp_stall = m_ext && cpu_valid;
            exp_we    = m_ext ? (ext_req && ext_we) : (cpu_valid && cpu_we);
            exp_addr  = m_ext ? ext_addr  : cpu_addr;
            exp_wd    = m_ext ? ext_wdata : cpu_wdata;
            check("rnd gnt", 64'(ext_gnt), 64'(exp_gnt));
            check("rnd stall", 64'(cpu_stall), 64'(exp_stall));
            check("rnd mem_we", 64'(mem_we), 64'(exp_we));
            check("rnd mem_addr", 64'(mem_addr), 64'(exp_addr));
            if (exp_we) check("rnd mem_wdata", 64'(mem_wdata), 64'(exp_wd));
            check("rnd rvalid", 64'(ext_rvalid), 64'(m_rvalid));
            if (m_rvalid) check("rnd rdata", 64'(ext_rdata), 64'(m_rdata));
            if (!m_ext && cpu_valid && !cpu_we)
                check("rnd cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[cpu_addr[9:2]]));

            m_rvalid = exp_gnt && !ext_we;
            if (m_rvalid) m_rdata = ref_mem[ext_addr[9:2]];
            if (exp_we) ref_mem[exp_addr[9:2]] = exp_wd;
            if (m_ext) begin
                if (exp_gnt) m_beats++;
                if (!ext_req || (cpu_valid && m_beats >= BURST_MAX)) m_ext = 1'b0;
                m_waited = 0;
            end else begin
                m_waited = (ext_req && cpu_valid) ? m_waited + 1 : 0;
                if (ext_req && (!cpu_valid || m_waited >= STARVE_LIMIT)) begin
                    m_ext    = 1'b1;
                    m_beats  = 0;
                    m_waited = 0;
                end
            end
            last_gnt = exp_gnt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
